// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32I decode constants, buffer state encoding and payload types.
package decode_stage_pkg;
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
  localparam int XLEN = `REG_WIDTH;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SRL, F3_OR, F3_AND} funct3_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
  typedef enum logic [1:0] {A_RS1, A_ZERO, A_PC} opa_t;
  typedef struct packed {
    logic [3:0]      funct;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            sel_imm;
    logic            we;
    logic            illegal;
    opa_t            a_sel;
  } dec_t;
  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      funct;
    logic            sel_imm;
    logic            we;
    logic            illegal;
  } pay_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, register-file, writeback and execute-side signals of the decode stage.
interface decode_stage_if;
  import decode_stage_pkg::*;
  logic            if_valid_i, if_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic [4:0]      rs1_addr_o, rs2_addr_o;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            ex_valid_o, ex_ready_i;
  logic [XLEN-1:0] rst1_read_o, rst2_read_o, imm_o;
  logic [4:0]      rd_o;
  logic [3:0]      funct_o;
  logic            op_sel_imm_o, we_o, illegal_o;
  modport slave (
    input  if_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, wb_we_i, wb_rd_i, wb_data_i, ex_ready_i,
    output if_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, rst1_read_o, rst2_read_o, imm_o, rd_o,
           funct_o, op_sel_imm_o, we_o, illegal_o
  );
  modport master (
    output if_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, wb_we_i, wb_rd_i, wb_data_i, ex_ready_i,
    input  if_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, rst1_read_o, rst2_read_o, imm_o, rd_o,
           funct_o, op_sel_imm_o, we_o, illegal_o
  );
endinterface

// File: rtl/decode_stage_decode_comb.sv
// decode_comb: combinational RV32I decode of OP/OP-IMM/LUI/AUIPC; illegal words decode as NOP_INSTR.
module decode_comb import decode_stage_pkg::*; #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);
  logic [6:0] opc, f7;
  funct3_t    f3;
  logic       ill;
  logic [31:0] ins;
  assign opc = instr_i[6:0];
  assign f7  = instr_i[31:25];
  assign f3  = funct3_t'(instr_i[14:12]);
  assign ill = (opc == OPC_OP)    ? !(f7 == 7'h00 || f7 == 7'h20) :
               (opc == OPC_OPIMM) ? (f3 == F3_SLL && f7 != 7'h00) || (f3 == F3_SRL && f7 != 7'h00 && f7 != 7'h20) :
               !(opc == OPC_LUI || opc == OPC_AUIPC);
  assign ins = ill ? NOP_INSTR : instr_i;
  assign dec_o.funct = (ins[6:0] == OPC_OP)    ? {ins[30], ins[14:12]} :
                       (ins[6:0] == OPC_OPIMM) ? {ins[30] && ins[14:12] == F3_SRL, ins[14:12]} : 4'b0000;
  assign dec_o.imm = (ins[6:0] == OPC_LUI || ins[6:0] == OPC_AUIPC) ? {ins[31:12], 12'b0} :
                     (ins[6:0] == OPC_OPIMM) ? {{20{ins[31]}}, ins[31:20]} : '0;
  assign dec_o.rd      = ins[11:7];
  assign dec_o.sel_imm = ins[6:0] != OPC_OP;
  assign dec_o.we      = !ill && ins[11:7] != 5'd0;
  assign dec_o.illegal = ill;
  // The substituted NOP reads x0, so operand A is forced to zero for illegal words.
  assign dec_o.a_sel = (ill || opc == OPC_LUI) ? A_ZERO : (opc == OPC_AUIPC) ? A_PC : A_RS1;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with registered output slot and one-entry skid buffer.
// Optional writeback bypass of captured operands when DECODE_BYPASS_EN is defined.
module decode_stage import decode_stage_pkg::*; #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk_sys_i,
  input  logic           rst_sys_i,
  input  logic           flush_i,
  decode_stage_if.slave  bus
);
  dec_t            dec;
  pay_t            in_p, out_q, out_d, skid_q, skid_d;
  state_t          state_q, state_d;
  logic            rdy_q, acc;
  logic [XLEN-1:0] rs1_v, rs2_v;
  assign bus.rs1_addr_o = bus.instr_i[19:15];
  assign bus.rs2_addr_o = bus.instr_i[24:20];
  decode_comb #(.NOP_INSTR(NOP_INSTR)) u_dec (.instr_i(bus.instr_i), .dec_o(dec));
`ifdef DECODE_BYPASS_EN
  assign rs1_v = (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == bus.rs1_addr_o) ? bus.wb_data_i : bus.rs1_data_i;
  assign rs2_v = (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == bus.rs2_addr_o) ? bus.wb_data_i : bus.rs2_data_i;
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_we_i, bus.wb_rd_i, bus.wb_data_i};
  assign rs1_v = bus.rs1_data_i;
  assign rs2_v = bus.rs2_data_i;
`endif
  always_comb begin
    in_p.op_a    = (dec.a_sel == A_PC) ? bus.pc_i : (dec.a_sel == A_ZERO) ? '0 : rs1_v;
    in_p.op_b    = rs2_v;
    in_p.imm     = dec.imm;
    in_p.rd      = dec.rd;
    in_p.funct   = dec.funct;
    in_p.sel_imm = dec.sel_imm;
    in_p.we      = dec.we;
    in_p.illegal = dec.illegal;
  end
  assign acc = bus.if_valid_i && rdy_q && !flush_i;
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          out_d   = in_p;
        end
      end
      ST_ONE: begin
        if (acc && bus.ex_ready_i) out_d = in_p;
        else if (acc) begin
          state_d = ST_TWO;
          skid_d  = in_p;
        end else if (bus.ex_ready_i) state_d = ST_EMPTY;
      end
      ST_TWO: begin
        if (bus.ex_ready_i) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d != ST_TWO;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end
  assign bus.if_ready_o   = rdy_q;
  assign bus.ex_valid_o   = state_q != ST_EMPTY;
  assign bus.rst1_read_o  = out_q.op_a;
  assign bus.rst2_read_o  = out_q.op_b;
  assign bus.imm_o        = out_q.imm;
  assign bus.rd_o         = out_q.rd;
  assign bus.funct_o      = out_q.funct;
  assign bus.op_sel_imm_o = out_q.sel_imm;
  assign bus.we_o         = out_q.we;
  assign bus.illegal_o    = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage covering decode, backpressure, flush and reset.
module tb_decode_stage;
  import decode_stage_pkg::*;
  typedef struct packed {
    logic [31:0] ins, pc, a, b, imm;
    logic [4:0]  rd;
    logic [3:0]  fn;
    logic        sel, we, ill, rt, wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
  } ent_t;
`ifdef DECODE_BYPASS_EN
  localparam logic [31:0] BYP_A = 32'h55;
`else
  localparam logic [31:0] BYP_A = 32'h7;
`endif
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;
  decode_stage_if bus();
  decode_stage dut (.clk_sys_i(clk), .rst_sys_i(rst), .flush_i(flush), .bus(bus));
  int   n_cmp = 0, n_err = 0;
  ent_t sb[$];
  ent_t tbl[11];
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : (a == 5'd1) ? 32'h7 : 32'h100 + {27'h0, a};
  endfunction
  function automatic ent_t mk(input logic [31:0] ins, pc, a, b, imm, input logic [4:0] rd,
                              input logic [3:0] fn, input logic [3:0] flg);
    ent_t e;
    e = '0;
    e.ins = ins; e.pc = pc; e.a = a; e.b = b; e.imm = imm; e.rd = rd; e.fn = fn;
    {e.sel, e.we, e.ill, e.rt} = flg;
    return e;
  endfunction
  always_comb begin
    bus.rs1_data_i = rf(bus.rs1_addr_o);
    bus.rs2_data_i = rf(bus.rs2_addr_o);
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    ent_t e;
    if (!rst && bus.ex_valid_o && bus.ex_ready_i) begin
      if (sb.size() == 0) check("spurious_valid", {31'h0, bus.ex_valid_o}, 32'h0);
      else begin
        e = sb.pop_front();
        check("op_a", bus.rst1_read_o, e.a);
        if (e.rt) check("op_b", bus.rst2_read_o, e.b);
        else check("imm", bus.imm_o, e.imm);
        check("rd", {27'h0, bus.rd_o}, {27'h0, e.rd});
        check("funct", {28'h0, bus.funct_o}, {28'h0, e.fn});
        check("sel_imm", {31'h0, bus.op_sel_imm_o}, {31'h0, e.sel});
        check("we", {31'h0, bus.we_o}, {31'h0, e.we});
        check("illegal", {31'h0, bus.illegal_o}, {31'h0, e.ill});
      end
    end
  end
  task automatic send(input ent_t e);
    logic done;
    done = 1'b0;
    bus.if_valid_i = 1'b1;
    bus.instr_i = e.ins;
    bus.pc_i = e.pc;
    bus.wb_we_i = e.wbe;
    bus.wb_rd_i = e.wbr;
    bus.wb_data_i = e.wbd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.if_ready_o && !flush) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", {31'h0, bus.if_ready_o}, 32'h1);
    bus.if_valid_i = 1'b0;
    bus.wb_we_i = 1'b0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle_checks(input string tag);
    check({tag, "_ex_valid"}, {31'h0, bus.ex_valid_o}, 32'h0);
    check({tag, "_if_ready"}, {31'h0, bus.if_ready_o}, 32'h1);
  endtask
  task automatic zero_checks(input string tag);
    check({tag, "_op_a"}, bus.rst1_read_o, 32'h0);
    check({tag, "_imm"}, bus.imm_o, 32'h0);
    check({tag, "_flags"}, {25'h0, bus.rd_o, bus.op_sel_imm_o, bus.we_o}, 32'h0);
    check({tag, "_illegal"}, {27'h0, bus.funct_o, bus.illegal_o}, 32'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = mk(32'hFFF08293, 32'h0, 32'h7, 32'h0, 32'hFFFF_FFFF, 5'd5, 4'h0, 4'b1100);
    tbl[1]  = mk(32'h402081B3, 32'h0, 32'h7, 32'h102, 32'h0, 5'd3, 4'h8, 4'b0101);
    tbl[2]  = mk(32'h123450B7, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 5'd1, 4'h0, 4'b1100);
    tbl[3]  = mk(32'h00001117, 32'h2000, 32'h2000, 32'h0, 32'h1000, 5'd2, 4'h0, 4'b1100);
    tbl[4]  = mk(32'h4030D213, 32'h0, 32'h7, 32'h0, 32'h403, 5'd4, 4'hD, 4'b1100);
    tbl[5]  = mk(32'h00000000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'h0, 4'b1010);
    tbl[6]  = mk(32'h40309213, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'h0, 4'b1010);
    tbl[7]  = mk(32'h0020C033, 32'h0, 32'h7, 32'h102, 32'h0, 5'd0, 4'h4, 4'b0001);
    tbl[8]  = mk(32'hFFF08293, 32'h0, BYP_A, 32'h0, 32'hFFFF_FFFF, 5'd5, 4'h0, 4'b1100);
    tbl[8].wbe = 1'b1; tbl[8].wbr = 5'd1; tbl[8].wbd = 32'h55;
    tbl[9]  = mk(32'h00500313, 32'h0, 32'h0, 32'h0, 32'h5, 5'd6, 4'h0, 4'b1100);
    tbl[9].wbe = 1'b1; tbl[9].wbr = 5'd0; tbl[9].wbd = 32'h55;
    tbl[10] = mk(32'h022080B3, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'h0, 4'b1010);
    bus.if_valid_i = 1'b0; bus.instr_i = '0; bus.pc_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_rd_i = '0; bus.wb_data_i = '0; bus.ex_ready_i = 1'b0;
    #1 rst = 1'b1;
    cycles(2);
    idle_checks("reset");
    zero_checks("reset");
    rst = 1'b0;
    cycles(1);
    bus.ex_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) send(tbl[i]);
    cycles(3);
    bus.ex_ready_i = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    check("two_if_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("two_ex_valid", {31'h0, bus.ex_valid_o}, 32'h1);
    fork
      send(tbl[2]);
      begin
        cycles(2);
        bus.ex_ready_i = 1'b1;
      end
    join
    cycles(3);
    bus.ex_ready_i = 1'b0;
    send(tbl[3]);
    send(tbl[4]);
    bus.if_valid_i = 1'b1;
    bus.instr_i = tbl[5].ins;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    bus.if_valid_i = 1'b0;
    sb.delete();
    idle_checks("flush");
    bus.ex_ready_i = 1'b1;
    cycles(3);
    send(tbl[9]);
    cycles(2);
    bus.ex_ready_i = 1'b0;
    send(tbl[2]);
    send(tbl[4]);
    #2 rst = 1'b1;
    #1;
    idle_checks("async_rst");
    zero_checks("async_rst");
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.ex_ready_i = 1'b1;
    send(tbl[8]);
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycles(1);
    check("drain", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
